zx_ce_gen: RTL and testbench



---
 rtl/zx_ce_gen.sv | 174 +++++++++++++++++
 tb/tb_zx_ce_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_ce_gen.sv
// zx_ce_gen: PLL-lock debounce and 56 MHz clock-enable generator.
// Optional ZX_CE_GEN_LOSS_CNT_EN builds the saturating lock-loss counter.
module zx_ce_gen #(
  parameter int unsigned LOCK_DEBOUNCE = 1024
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic [1:0] turbo,
  input  logic       pause,
  output logic       ready,
  output logic       ce_28m,
  output logic       ce_14m,
  output logic       ce_7m_p,
  output logic       ce_7m_n,
  output logic       ce_cpu_p,
  output logic       ce_cpu_n,
  output logic [7:0] lock_loss
);

  typedef enum logic {
    ST_WAIT,
    ST_RUN
  } state_t;

  localparam logic [15:0] DBC_LAST = 16'(LOCK_DEBOUNCE - 1);

  logic        sync1_q;
  logic        sync2_q;
  state_t      state_q;
  state_t      state_d;
  logic [15:0] dbc_q;
  logic [15:0] dbc_d;
  logic        go_run;
  logic        ready_q;
  logic        ready_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [1:0]  turbo_q;
  logic [1:0]  turbo_d;
  logic        pause_q;
  logic        pause_d;
  logic        load;
  logic [3:0]  mask;
  logic [3:0]  phase;
  logic        en;
  logic [5:0]  ce_q;
  logic [5:0]  ce_d;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      dbc_q   <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      turbo_q <= '0;
      pause_q <= 1'b0;
      ce_q    <= '0;
    end else begin
      state_q <= state_d;
      dbc_q   <= dbc_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      turbo_q <= turbo_d;
      pause_q <= pause_d;
      ce_q    <= ce_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    go_run  = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (!sync2_q) begin
          dbc_d = '0;
        end else if (dbc_q == DBC_LAST) begin
          state_d = ST_RUN;
          dbc_d   = '0;
          go_run  = 1'b1;
        end else begin
          dbc_d = dbc_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (!sync2_q) begin
          state_d = ST_WAIT;
          dbc_d   = '0;
        end
      end
    endcase
  end

  // ready drops on the same edge the FSM leaves RUN
  assign ready_d = (state_q == ST_RUN) && sync2_q;

  // phase stays at 0 until ready is visible, then free-runs
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != ST_RUN) begin
      cnt_d = '0;
    end else if (ready_q) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign load    = go_run || (ready_q && (cnt_q == 4'hF));
  assign turbo_d = load ? turbo : turbo_q;
  assign pause_d = load ? pause : pause_q;

  always_comb begin
    mask = 4'hF;
    unique case (turbo_q)
      2'd0: mask = 4'hF;
      2'd1: mask = 4'h7;
      2'd2: mask = 4'h3;
      2'd3: mask = 4'h1;
    endcase
  end

  assign phase = cnt_q & mask;
  assign en    = ready_d && ready_q;

  always_comb begin
    ce_d    = '0;
    ce_d[5] = en && cnt_q[0];
    ce_d[4] = en && (cnt_q[1:0] == 2'd3);
    ce_d[3] = en && (cnt_q[2:0] == 3'd3);
    ce_d[2] = en && (cnt_q[2:0] == 3'd7);
    ce_d[1] = en && !pause_q && (phase == (mask >> 1));
    ce_d[0] = en && !pause_q && (phase == mask);
  end

  assign ready    = ready_q;
  assign ce_28m   = ce_q[5];
  assign ce_14m   = ce_q[4];
  assign ce_7m_p  = ce_q[3];
  assign ce_7m_n  = ce_q[2];
  assign ce_cpu_p = ce_q[1];
  assign ce_cpu_n = ce_q[0];

`ifdef ZX_CE_GEN_LOSS_CNT_EN
  logic       lost;
  logic [7:0] loss_q;
  logic [7:0] loss_d;

  assign lost   = (state_q == ST_RUN) && !sync2_q;
  assign loss_d = (lost && (loss_q != 8'hFF)) ? loss_q + 8'd1 : loss_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss = loss_q;
`else
  assign lock_loss = 8'd0;
`endif

endmodule

// File: tb/tb_zx_ce_gen.sv
// tb_zx_ce_gen: directed + random stimulus against a
// timing-rule reference model of zx_ce_gen.
module tb_zx_ce_gen;
  localparam int D = 8;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic [1:0] turbo;
  logic       pause;
  logic       ready;
  logic       ce_28m;
  logic       ce_14m;
  logic       ce_7m_p;
  logic       ce_7m_n;
  logic       ce_cpu_p;
  logic       ce_cpu_n;
  logic [7:0] lock_loss;

  zx_ce_gen #(.LOCK_DEBOUNCE(D)) dut (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .turbo(turbo),
    .pause(pause),
    .ready(ready),
    .ce_28m(ce_28m),
    .ce_14m(ce_14m),
    .ce_7m_p(ce_7m_p),
    .ce_7m_n(ce_7m_n),
    .ce_cpu_p(ce_cpu_p),
    .ce_cpu_n(ce_cpu_n),
    .lock_loss(lock_loss)
  );

  always #5 clk_sys = ~clk_sys;

  wire [14:0] obs = {ready, ce_28m, ce_14m, ce_7m_p, ce_7m_n,
                     ce_cpu_p, ce_cpu_n, lock_loss};

  int n_assert = 0;
  int n_fail = 0;
  int last_cpu = 0;

  // model: ready needs D+1 consecutive high samples seen 2 edges late
  int         cyc;
  int         rise_e;
  int         run_len;
  int         dl0;
  int         dl1;
  bit         m_rdy;
  logic [1:0] m_turbo;
  logic [1:0] prev_turbo;
  bit         m_pause;
  bit         prev_pause;
  int         m_loss;
  logic [14:0] exp_v;

  task automatic model_reset();
    cyc = 0; rise_e = 0; run_len = 0; dl0 = 0; dl1 = 0;
    m_rdy = 0; m_turbo = 0; prev_turbo = 0;
    m_pause = 0; prev_pause = 0; m_loss = 0;
    exp_v = '0;
  endtask

  function automatic int m_phase();
    return (cyc - rise_e - 1) % 16;
  endfunction

  task automatic model_edge();
    int rdel;
    int ph;
    int p;
    bit was;
    bit e28, e14, e7p, e7n, ecp, ecn;
    cyc++;
    run_len = pll_locked ? (run_len < 100000 ? run_len + 1 : run_len) : 0;
    rdel = dl1; dl1 = dl0; dl0 = run_len;
    was = m_rdy;
    m_rdy = (rdel >= D + 1);
    if (m_rdy && !was) begin
      rise_e = cyc;
      m_turbo = prev_turbo;
      m_pause = prev_pause;
    end
`ifdef ZX_CE_GEN_LOSS_CNT_EN
    if (!m_rdy && was && m_loss < 255) m_loss++;
`endif
    {e28, e14, e7p, e7n, ecp, ecn} = '0;
    if (m_rdy && was) begin
      ph = m_phase();
      p = 16 >> m_turbo;
      e28 = (ph % 2) == 1;
      e14 = (ph % 4) == 3;
      e7p = (ph % 8) == 3;
      e7n = (ph % 8) == 7;
      ecp = !m_pause && ((ph % p) == p / 2 - 1);
      ecn = !m_pause && ((ph % p) == p - 1);
      if (ph == 15) begin
        m_turbo = turbo;
        m_pause = pause;
      end
    end
    prev_turbo = turbo;
    prev_pause = pause;
    exp_v = {m_rdy, e28, e14, e7p, e7n, ecp, ecn, 8'(m_loss)};
  endtask

  task automatic step();
    bit alt_ok;
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL outputs cyc=%0d observed=%h expected=%h", cyc, obs, exp_v);
    end
    if (!ready) last_cpu = 0;
    if (ce_cpu_p || ce_cpu_n) begin
      alt_ok = !(ce_cpu_p && ce_cpu_n) &&
               ((ce_cpu_p && last_cpu != 1) || (ce_cpu_n && last_cpu == 1));
      n_assert++;
      assert (alt_ok === 1'b1) else begin
        n_fail++;
        $error("FAIL cpu_alternation cyc=%0d observed=%b%b last=%0d",
               cyc, ce_cpu_p, ce_cpu_n, last_cpu);
      end
      last_cpu = ce_cpu_p ? 1 : 2;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input bit lvl, input int lim, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ready !== lvl && n < lim);
  endtask

  int n;
  int c_cpu;
  int c14;
  int exp_loss;

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b1;
    turbo = 2'd0;
    pause = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", int'(obs), 0);
    rst_n = 1'b1;

    wait_ready(1'b1, 40, n);
    check("ready_latency", n, 11);
    n = 0;
    do begin step(); n++; end while (!ce_28m && n < 10);
    check("first_ce28", n, 2);

    for (int t = 0; t < 4; t++) begin
      turbo = 2'(t);
      repeat (20) step();
      n = 0;
      do begin step(); n++; end while (!ce_cpu_p && n < 40);
      n = 0;
      do begin step(); n++; end while (!ce_cpu_n && n < 40);
      check("cpu_p_to_n", n, (16 >> t) / 2);
      n = 0;
      do begin step(); n++; end while (!ce_cpu_p && n < 40);
      check("cpu_n_to_p", n, (16 >> t) / 2);
    end

    turbo = 2'd0;
    repeat (20) step();
    n = 0;
    do begin step(); n++; end while (m_phase() != 3 && n < 40);
    turbo = 2'd3;
    repeat (20) step();
    c_cpu = 0;
    repeat (8) begin
      step();
      c_cpu += int'(ce_cpu_p) + int'(ce_cpu_n);
    end
    check("fast_cpu_count", c_cpu, 8);

    turbo = 2'd1;
    repeat (25) step();
    pause = 1'b1;
    repeat (20) step();
    c_cpu = 0;
    c14 = 0;
    repeat (16) begin
      step();
      c_cpu += int'(ce_cpu_p) + int'(ce_cpu_n);
      c14 += int'(ce_14m);
    end
    check("pause_cpu", c_cpu, 0);
    check("pause_ce14", c14, 4);
    pause = 1'b0;
    n = 0;
    do begin step(); n++; end while (!(ce_cpu_p || ce_cpu_n) && n < 40);
    check("resume_with_p", int'(ce_cpu_p), 1);

    repeat (600) begin
      if ($urandom_range(0, 7) == 0) turbo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      if ($urandom_range(0, 99) == 0) begin
        pll_locked = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        pll_locked = 1'b1;
      end
      step();
    end

    @(posedge clk_sys);
    #2 rst_n = 1'b0;
    #1 check("async_reset", int'(obs), 0);
    model_reset();
    last_cpu = 0;
    pause = 1'b0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    wait_ready(1'b1, 40, n);
    repeat (10) step();

`ifdef ZX_CE_GEN_LOSS_CNT_EN
    exp_loss = 1;
`else
    exp_loss = 0;
`endif
    pll_locked = 1'b0;
    wait_ready(1'b0, 10, n);
    check("loss_latency", n, 3);
    check("loss_ce_zero", int'(obs[13:8]), 0);
    check("loss_count_one", int'(lock_loss), exp_loss);

    repeat (300) begin
      pll_locked = 1'b1;
      wait_ready(1'b1, 30, n);
      pll_locked = 1'b0;
      wait_ready(1'b0, 10, n);
    end
`ifdef ZX_CE_GEN_LOSS_CNT_EN
    exp_loss = 255;
`else
    exp_loss = 0;
`endif
    check("loss_saturate", int'(lock_loss), exp_loss);

    @(negedge clk_sys);
    rst_n = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    last_cpu = 0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) step();
    pll_locked = 1'b1;
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_ready(1'b1, 40, n);
    check("glitch_ready_latency", n, 11);
    check("glitch_no_loss", int'(lock_loss), 0);
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
